// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU/branch ops, captures operands
// from the ALU and LSB broadcast buses, and issues one ready op per cycle.
module alu_rs #(
   parameter int unsigned RS_SIZE = 8,
   parameter int unsigned ROB_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clear,
   input  logic             issue_en,
   input  logic [ROB_W-1:0] issue_rob_id,
   input  logic [5:0]       issue_opcode,
   input  logic [31:0]      issue_vj,
   input  logic             issue_qj_busy,
   input  logic [ROB_W-1:0] issue_qj,
   input  logic [31:0]      issue_vk,
   input  logic             issue_qk_busy,
   input  logic [ROB_W-1:0] issue_qk,
   input  logic [31:0]      issue_imm,
   input  logic [31:0]      issue_pc,
   input  logic             alu_cdb_ok,
   input  logic [ROB_W-1:0] alu_cdb_rob_id,
   input  logic [31:0]      alu_cdb_res,
   input  logic             lsb_cdb_ok,
   input  logic [ROB_W-1:0] lsb_cdb_rob_id,
   input  logic [31:0]      lsb_cdb_res,
   output logic             rs_full,
   output logic             work_en,
   output logic [ROB_W-1:0] rob_id,
   output logic [5:0]       opcode,
   output logic [31:0]      rs1,
   output logic [31:0]      rs2,
   output logic [31:0]      imm,
   output logic [31:0]      pc
);

   localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] qj_busy;
   logic [RS_SIZE-1:0] qk_busy;
   logic [ROB_W-1:0]   e_rob_id [RS_SIZE];
   logic [5:0]         e_opcode [RS_SIZE];
   logic [31:0]        e_vj     [RS_SIZE];
   logic [ROB_W-1:0]   e_qj     [RS_SIZE];
   logic [31:0]        e_vk     [RS_SIZE];
   logic [ROB_W-1:0]   e_qk     [RS_SIZE];
   logic [31:0]        e_imm    [RS_SIZE];
   logic [31:0]        e_pc     [RS_SIZE];

   logic [IDX_W-1:0] free_idx;
   logic             free_found;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic             insert_ok;
   logic             in_qj_busy;
   logic             in_qk_busy;
   logic [31:0]      in_vj;
   logic [31:0]      in_vk;

   // ALU bus takes precedence when both buses carry the same tag
   function automatic logic cdb_hit(input logic [ROB_W-1:0] tag);
      return (alu_cdb_ok && (alu_cdb_rob_id == tag)) ||
             (lsb_cdb_ok && (lsb_cdb_rob_id == tag));
   endfunction

   function automatic logic [31:0] cdb_val(input logic [ROB_W-1:0] tag);
      return (alu_cdb_ok && (alu_cdb_rob_id == tag)) ? alu_cdb_res : lsb_cdb_res;
   endfunction

   assign rs_full   = &busy;
   assign insert_ok = issue_en && !rs_full;

   // Lowest-index free slot and lowest-index ready slot, both on registered state
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      pick_idx   = '0;
      pick_found = 1'b0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!busy[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (busy[i] && !qj_busy[i] && !qk_busy[i] && !pick_found) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
   end

   // Same-cycle broadcast bypass for an incoming instruction
   always_comb begin
      in_qj_busy = issue_qj_busy;
      in_vj      = issue_vj;
      in_qk_busy = issue_qk_busy;
      in_vk      = issue_vk;
      if (issue_qj_busy && cdb_hit(issue_qj)) begin
         in_qj_busy = 1'b0;
         in_vj      = cdb_val(issue_qj);
      end
      if (issue_qk_busy && cdb_hit(issue_qk)) begin
         in_qk_busy = 1'b0;
         in_vk      = cdb_val(issue_qk);
      end
   end

   // Control state and issue bundle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= '0;
         qj_busy <= '0;
         qk_busy <= '0;
         work_en <= 1'b0;
         rob_id  <= '0;
         opcode  <= '0;
         rs1     <= '0;
         rs2     <= '0;
         imm     <= '0;
         pc      <= '0;
      end else if (rdy) begin
         if (clear) begin
            busy    <= '0;
            work_en <= 1'b0;
         end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && qj_busy[i] && cdb_hit(e_qj[i])) qj_busy[i] <= 1'b0;
               if (busy[i] && qk_busy[i] && cdb_hit(e_qk[i])) qk_busy[i] <= 1'b0;
            end
            if (pick_found) begin
               work_en        <= 1'b1;
               rob_id         <= e_rob_id[pick_idx];
               opcode         <= e_opcode[pick_idx];
               rs1            <= e_vj[pick_idx];
               rs2            <= e_vk[pick_idx];
               imm            <= e_imm[pick_idx];
               pc             <= e_pc[pick_idx];
               busy[pick_idx] <= 1'b0;
            end else begin
               work_en <= 1'b0;
            end
            if (insert_ok) begin
               busy[free_idx]    <= 1'b1;
               qj_busy[free_idx] <= in_qj_busy;
               qk_busy[free_idx] <= in_qk_busy;
            end
         end
      end
   end

   // Entry payload; meaningless while the slot is not busy, so no reset
   always_ff @(posedge clk) begin
      if (rdy && !clear) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && qj_busy[i] && cdb_hit(e_qj[i])) e_vj[i] <= cdb_val(e_qj[i]);
            if (busy[i] && qk_busy[i] && cdb_hit(e_qk[i])) e_vk[i] <= cdb_val(e_qk[i]);
         end
         if (insert_ok) begin
            e_rob_id[free_idx] <= issue_rob_id;
            e_opcode[free_idx] <= issue_opcode;
            e_vj[free_idx]     <= in_vj;
            e_qj[free_idx]     <= issue_qj;
            e_vk[free_idx]     <= in_vk;
            e_qk[free_idx]     <= issue_qk;
            e_imm[free_idx]    <= issue_imm;
            e_pc[free_idx]     <= issue_pc;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, scored against a
// slot-level behavioural model through an expected-output queue.
module tb_alu_rs;

   localparam int unsigned RS_SIZE = 8;
   localparam int unsigned ROB_W   = 4;

   logic             clk = 1'b0;
   logic             rst, rdy, clear, issue_en;
   logic [ROB_W-1:0] issue_rob_id, issue_qj, issue_qk;
   logic [5:0]       issue_opcode;
   logic [31:0]      issue_vj, issue_vk, issue_imm, issue_pc;
   logic             issue_qj_busy, issue_qk_busy;
   logic             alu_cdb_ok, lsb_cdb_ok;
   logic [ROB_W-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
   logic [31:0]      alu_cdb_res, lsb_cdb_res;
   logic             rs_full, work_en;
   logic [ROB_W-1:0] rob_id;
   logic [5:0]       opcode;
   logic [31:0]      rs1, rs2, imm, pc;

   alu_rs #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .issue_en(issue_en), .issue_rob_id(issue_rob_id), .issue_opcode(issue_opcode),
      .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
      .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
      .issue_imm(issue_imm), .issue_pc(issue_pc),
      .alu_cdb_ok(alu_cdb_ok), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_res(alu_cdb_res),
      .lsb_cdb_ok(lsb_cdb_ok), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_res(lsb_cdb_res),
      .rs_full(rs_full), .work_en(work_en), .rob_id(rob_id), .opcode(opcode),
      .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               busy;
      logic [ROB_W-1:0] rob;
      logic [5:0]       op;
      logic [31:0]      vj;
      bit               qjb;
      logic [ROB_W-1:0] qj;
      logic [31:0]      vk;
      bit               qkb;
      logic [ROB_W-1:0] qk;
      logic [31:0]      imm;
      logic [31:0]      pc;
   } slot_t;

   typedef struct {
      int unsigned      cyc;
      bit               en;
      logic [ROB_W-1:0] rob;
      logic [5:0]       op;
      logic [31:0]      rs1;
      logic [31:0]      rs2;
      logic [31:0]      imm;
      logic [31:0]      pc;
   } out_t;

   slot_t       m [RS_SIZE];
   out_t        mo;
   out_t        exp_q [$];
   int unsigned cyc = 0;
   int          passed = 0;
   int          total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor: one expected record per clock edge
   always @(posedge clk) begin : mon
      out_t e;
      #2;
      if (!rst && exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         check("work_en", 32'(work_en), 32'(e.en));
         check("rob_id",  32'(rob_id),  32'(e.rob));
         check("opcode",  32'(opcode),  32'(e.op));
         check("rs1",     rs1,          e.rs1);
         check("rs2",     rs2,          e.rs2);
         check("imm",     imm,          e.imm);
         check("pc",      pc,           e.pc);
      end
   end

   function automatic void reset_model();
      for (int i = 0; i < int'(RS_SIZE); i++) m[i] = '{default: '0};
      mo = '{default: '0};
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < int'(RS_SIZE); i++) if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit cdb_lookup(input logic [ROB_W-1:0] tag, output logic [31:0] v);
      v = '0;
      if (alu_cdb_ok && alu_cdb_rob_id == tag) begin v = alu_cdb_res; return 1'b1; end
      if (lsb_cdb_ok && lsb_cdb_rob_id == tag) begin v = lsb_cdb_res; return 1'b1; end
      return 1'b0;
   endfunction

   // Predict the state/outputs after the coming edge from the current inputs
   function automatic void model_step();
      slot_t       pre [RS_SIZE];
      slot_t       s;
      int          r = -1;
      int          f = -1;
      bit          full;
      logic [31:0] v;
      if (rdy) begin
         if (clear) begin
            for (int i = 0; i < int'(RS_SIZE); i++) m[i].busy = 1'b0;
            mo.en = 1'b0;
         end else begin
            pre  = m;
            full = model_full();
            for (int i = 0; i < int'(RS_SIZE); i++) begin
               if (r < 0 && pre[i].busy && !pre[i].qjb && !pre[i].qkb) r = i;
               if (f < 0 && !pre[i].busy) f = i;
            end
            for (int i = 0; i < int'(RS_SIZE); i++) begin
               if (m[i].busy && m[i].qjb && cdb_lookup(m[i].qj, v)) begin m[i].vj = v; m[i].qjb = 1'b0; end
               if (m[i].busy && m[i].qkb && cdb_lookup(m[i].qk, v)) begin m[i].vk = v; m[i].qkb = 1'b0; end
            end
            if (r >= 0) begin
               mo.en = 1'b1; mo.rob = pre[r].rob; mo.op = pre[r].op;
               mo.rs1 = pre[r].vj; mo.rs2 = pre[r].vk; mo.imm = pre[r].imm; mo.pc = pre[r].pc;
               m[r].busy = 1'b0;
            end else begin
               mo.en = 1'b0;
            end
            if (issue_en && !full) begin
               s.busy = 1'b1; s.rob = issue_rob_id; s.op = issue_opcode;
               s.vj = issue_vj; s.qjb = issue_qj_busy; s.qj = issue_qj;
               s.vk = issue_vk; s.qkb = issue_qk_busy; s.qk = issue_qk;
               s.imm = issue_imm; s.pc = issue_pc;
               if (s.qjb && cdb_lookup(s.qj, v)) begin s.vj = v; s.qjb = 1'b0; end
               if (s.qkb && cdb_lookup(s.qk, v)) begin s.vk = v; s.qkb = 1'b0; end
               m[f] = s;
            end
         end
      end
      mo.cyc = cyc + 1;
      exp_q.push_back(mo);
   endfunction

   // Called one time unit after an edge; returns one time unit after the next
   task automatic step();
      check("rs_full", 32'(rs_full), 32'(model_full()));
      model_step();
      @(posedge clk);
      #1;
      issue_en = 1'b0; clear = 1'b0; alu_cdb_ok = 1'b0; lsb_cdb_ok = 1'b0;
   endtask

   task automatic set_issue(input logic [ROB_W-1:0] r, input logic [5:0] op,
                            input logic [31:0] vj, input logic qjb, input logic [ROB_W-1:0] qj,
                            input logic [31:0] vk, input logic qkb, input logic [ROB_W-1:0] qk,
                            input logic [31:0] im, input logic [31:0] p);
      issue_en = 1'b1; issue_rob_id = r; issue_opcode = op;
      issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
      issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk;
      issue_imm = im; issue_pc = p;
   endtask

   task automatic alu_bc(input logic [ROB_W-1:0] t, input logic [31:0] v);
      alu_cdb_ok = 1'b1; alu_cdb_rob_id = t; alu_cdb_res = v;
   endtask

   task automatic lsb_bc(input logic [ROB_W-1:0] t, input logic [31:0] v);
      lsb_cdb_ok = 1'b1; lsb_cdb_rob_id = t; lsb_cdb_res = v;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; clear = 1'b0; issue_en = 1'b0;
      issue_rob_id = '0; issue_opcode = '0; issue_vj = '0; issue_qj_busy = 1'b0; issue_qj = '0;
      issue_vk = '0; issue_qk_busy = 1'b0; issue_qk = '0; issue_imm = '0; issue_pc = '0;
      alu_cdb_ok = 1'b0; alu_cdb_rob_id = '0; alu_cdb_res = '0;
      lsb_cdb_ok = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_res = '0;
      reset_model();

      #12;
      check("rst_work_en", 32'(work_en), 32'd0);
      check("rst_rs_full", 32'(rs_full), 32'd0);
      check("rst_rob_id",  32'(rob_id),  32'd0);
      check("rst_rs1",     rs1,          32'd0);
      check("rst_pc",      pc,           32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Ready instruction issues exactly one cycle after insertion
      set_issue(4'd3, 6'h01, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'h10, 32'h100);
      step(); step(); step();

      // rs1 dependency woken by ALU broadcast
      set_issue(4'd2, 6'h02, 32'hdead, 1'b1, 4'd9, 32'd3, 1'b0, 4'd0, 32'h20, 32'h200);
      step(); step();
      alu_bc(4'd9, 32'h1234);
      step(); step(); step();

      // Same-cycle bypass from LSB bus into rs2
      set_issue(4'd4, 6'h03, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h30, 32'h300);
      lsb_bc(4'd5, 32'hffff_ffff);
      step(); step(); step();

      // Fill all slots, drop an extra issue, then release in index order
      for (int i = 0; i < int'(RS_SIZE); i++) begin
         set_issue(ROB_W'(i), 6'h04, 32'(i), 1'b1, 4'd1, 32'(i * 3), 1'b0, 4'd0, 32'(i), 32'h400 + 32'(i * 4));
         step();
      end
      check("full_flag", 32'(rs_full), 32'd1);
      set_issue(4'd15, 6'h3f, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'h99, 32'h999);
      step();
      check("full_hold", 32'(rs_full), 32'd1);
      alu_bc(4'd1, 32'hcafe_0001);
      step();
      repeat (10) step();

      // Flush with two ready and two waiting entries
      set_issue(4'd10, 6'h05, 32'd0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 32'd0, 32'h500); step();
      set_issue(4'd11, 6'h05, 32'd0, 1'b1, 4'd6, 32'd2, 1'b0, 4'd0, 32'd0, 32'h504); step();
      set_issue(4'd12, 6'h05, 32'd0, 1'b1, 4'd7, 32'd3, 1'b0, 4'd0, 32'd0, 32'h508); step();
      set_issue(4'd13, 6'h05, 32'd0, 1'b1, 4'd7, 32'd4, 1'b0, 4'd0, 32'd0, 32'h50c); step();
      alu_bc(4'd6, 32'h6666);
      step();
      clear = 1'b1;
      step();
      check("flush_work_en", 32'(work_en), 32'd0);
      check("flush_rs_full", 32'(rs_full), 32'd0);
      repeat (3) step();
      lsb_bc(4'd7, 32'h7777);
      step();
      repeat (3) step();

      // rdy low freezes everything; then async reset between edges
      set_issue(4'd6, 6'h06, 32'd0, 1'b1, 4'd8, 32'd8, 1'b0, 4'd0, 32'h60, 32'h600); step();
      alu_bc(4'd8, 32'h8888);
      step();
      rdy = 1'b0;
      set_issue(4'd7, 6'h07, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'h70, 32'h700);
      step();
      repeat (2) step();
      rdy = 1'b1;
      step();
      #2;
      check("pre_rst_work_en", 32'(work_en), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_work_en", 32'(work_en), 32'd0);
      check("async_rst_rob_id",  32'(rob_id),  32'd0);
      check("async_rst_rs1",     rs1,          32'd0);
      exp_q.delete();
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         rdy   = ($urandom_range(9) != 0);
         clear = ($urandom_range(49) == 0);
         if ($urandom_range(1) == 1)
            set_issue(4'($urandom_range(15)), 6'($urandom_range(63)),
                      $urandom, 1'($urandom_range(1)), 4'($urandom_range(3)),
                      $urandom, 1'($urandom_range(1)), 4'($urandom_range(3)),
                      $urandom, $urandom);
         if ($urandom_range(3) == 0) alu_bc(4'($urandom_range(3)), $urandom);
         if ($urandom_range(3) == 0) lsb_bc(4'($urandom_range(3)), $urandom);
         if (alu_cdb_ok && lsb_cdb_ok && alu_cdb_rob_id == lsb_cdb_rob_id) lsb_cdb_ok = 1'b0;
         step();
      end
      rdy = 1'b1;
      repeat (12) step();
      #5;
      if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the integer ALU in the out-of-order core. It is the issuing end of the ALU work interface.
- Accepts decoded ALU/branch/jump instructions from the dispatcher and tracks pending source operands by ROB tag.
- Snoops the two result broadcast buses (ALU, LSB) to capture operand values.
- Issues at most one ready instruction per cycle to the ALU through a registered work_en/rob_id/opcode/rs1/rs2/imm/pc bundle.

Parameters:
- RS_SIZE, 8, number of entries; power of two, at least 2.
- ROB_W, 4, ROB tag width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; when low, all state holds
- clear  in  1  mispredict flush
- issue_en  in  1  dispatcher presents an instruction this cycle
- issue_rob_id  in  ROB_W  destination ROB tag
- issue_opcode  in  6  internal opcode
- issue_vj  in  32  rs1 value, valid when issue_qj_busy=0
- issue_qj_busy  in  1  rs1 waits on tag issue_qj
- issue_qj  in  ROB_W  rs1 producer tag
- issue_vk  in  32  rs2 value, valid when issue_qk_busy=0
- issue_qk_busy  in  1  rs2 waits on tag issue_qk
- issue_qk  in  ROB_W  rs2 producer tag
- issue_imm  in  32  immediate
- issue_pc  in  32  instruction pc
- alu_cdb_ok  in  1  ALU result broadcast valid
- alu_cdb_rob_id  in  ROB_W  ALU broadcast tag
- alu_cdb_res  in  32  ALU broadcast value
- lsb_cdb_ok  in  1  LSB result broadcast valid
- lsb_cdb_rob_id  in  ROB_W  LSB broadcast tag
- lsb_cdb_res  in  32  LSB broadcast value
- rs_full  out  1  combinational; high when all RS_SIZE entries are busy
- work_en  out  1  registered; ALU work valid
- rob_id  out  ROB_W  registered; tag of issued instruction
- opcode  out  6  registered
- rs1  out  32  registered operand 1
- rs2  out  32  registered operand 2
- imm  out  32  registered
- pc  out  32  registered

Behaviour:
- Per-entry state: busy, opcode, rob_id, vj, qj_busy, qj, vk, qk_busy, qk, imm, pc.
- Reset (async, rst high): all busy=0, all q*_busy=0, work_en=0; rob_id, opcode, rs1, rs2, imm, pc = 0. rs_full therefore reads 0.
- All updates below occur only on posedge clk with rst low and rdy high. With rdy low, everything holds, including work_en.
- Priority: clear > {dispatch, insert, wakeup}.
- clear: all busy=0, work_en<=0 next edge. issue_en and broadcasts in the same cycle are ignored.
- Wakeup: for every busy entry with qj_busy and qj equal to a valid broadcast tag, set vj to that value and clear qj_busy. Same for qk. If ALU and LSB carry the same tag, ALU wins; this is illegal upstream.
- Dispatch:
  - Candidate = lowest-index entry with busy && !qj_busy && !qk_busy, evaluated on registered state. An operand woken this cycle becomes eligible next cycle.
  - If a candidate exists: work_en<=1 and the output bundle is loaded from the entry, with rs1=vj and rs2=vk. The entry's busy is cleared.
  - Otherwise work_en<=0. work_en is a one-cycle pulse per instruction.
  - Issue-to-ALU latency is at least 1 cycle after insertion of a ready instruction.
- Insert:
  - When issue_en && !rs_full, write the lowest-index entry with busy=0 (pre-edge state).
  - Same-cycle bypass: if issue_qj_busy and issue_qj matches a valid broadcast this cycle, store the broadcast value with qj_busy=0. Same for qk.
  - A freshly inserted entry is never dispatched in its insertion cycle.
- Full boundary:
  - rs_full reflects pre-edge state. An entry freed by dispatch is reusable only from the next cycle.
  - issue_en while rs_full is a protocol violation; the instruction is dropped and state is unchanged.
- Simultaneous dispatch and insert target different entries, because insert selects on pre-edge busy and the dispatched entry is busy pre-edge.
- Asynchronous reset asserted mid-operation discards every entry immediately, regardless of rdy.

Test Plan:
1. Ready insert: issue ADD rob_id=3, vj=5, vk=7, no deps -> work_en=1 exactly one cycle later with rob_id=3, rs1=5, rs2=7, single-cycle pulse.
2. Dependency wakeup: insert rob_id=2, qj_busy tag=9; two cycles later alu_cdb_ok tag=9 res=0x1234 -> work_en the cycle after the broadcast, rs1=0x1234.
3. Same-cycle bypass: issue qk_busy tag=5 while lsb_cdb_ok tag=5 res=0xFFFF_FFFF -> dispatched next cycle with rs2=0xFFFF_FFFF.
4. Full and ordering: fill 8 entries all waiting on tag 1 -> rs_full=1. Extra issue_en is dropped. Broadcast tag 1 -> entries dispatch in index order, one per cycle, over 8 consecutive cycles.
5. Flush: 4 busy entries, 2 of them ready, clear asserted -> next cycle work_en=0, rs_full=0, and no further dispatch without new inserts.
6. rdy/reset: hold rdy low with a ready entry -> no dispatch and outputs frozen. Assert rst asynchronously between edges -> work_en drops to 0 without a clock edge.
